// File: rtl/unified_cache_arbiter.sv
// unified_cache_arbiter: two-requester front end for the unified cache.
// Arbitrates an instruction-fetch port (read-only) and a data port (read/write),
// registers the winner's request onto the cache macc/rd/addr/din handshake,
// returns data with a one-cycle ack, and aborts accesses that never complete.
//
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   i_req/i_addr              fetch request (level) and address
//   i_ack/i_dout              fetch done pulse and fetch data
//   d_req/d_rd/d_addr/d_din   data request, direction (1=read), address, write data
//   d_ack/d_dout              data done pulse and read data
//   err                       pulses with ack when the access timed out
//   busy                      high whenever the arbiter is not idle
//   c_macc/c_rd/c_addr/c_din  cache access strobe, direction, address, write data
//   c_dout/c_complete         cache read data and completion
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on ties
// (otherwise the data port always wins a tie).
module unified_cache_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_dout,
    input  logic          d_req,
    input  logic          d_rd,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_din,
    output logic          d_ack,
    output logic [DW-1:0] d_dout,
    output logic          err,
    output logic          busy,
    output logic          c_macc,
    output logic          c_rd,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_din,
    input  logic [DW-1:0] c_dout,
    input  logic          c_complete
);

    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          c_macc_q, c_macc_d;
    logic          c_rd_q, c_rd_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [DW-1:0] c_din_q, c_din_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] i_dout_q, i_dout_d;
    logic [DW-1:0] d_dout_q, d_dout_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;
    // Port owning the current access (1 = data port); also serves as the
    // last-grant record for round-robin tie breaking.
    logic          owner_q, owner_d;
    logic          pick_d;

    // Tie-break between simultaneous requests.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = d_req && (!i_req || !owner_q);
`else
        pick_d = d_req;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        c_macc_d = c_macc_q;
        c_rd_d   = c_rd_q;
        c_addr_d = c_addr_q;
        c_din_d  = c_din_q;
        i_dout_d = i_dout_q;
        d_dout_d = d_dout_q;
        timer_d  = timer_q;
        owner_d  = owner_q;
        i_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    owner_d  = pick_d;
                    c_macc_d = 1'b1;
                    timer_d  = '0;
                    state_d  = S_ISSUE;
                    if (pick_d) begin
                        c_addr_d = d_addr;
                        c_din_d  = d_din;
                        c_rd_d   = d_rd;
                    end else begin
                        c_addr_d = i_addr;
                        c_rd_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (c_complete) begin
                    // Completion beats a simultaneous timeout.
                    if (c_rd_q) begin
                        if (owner_q) d_dout_d = c_dout;
                        else         i_dout_d = c_dout;
                    end
                    c_macc_d = 1'b0;
                    i_ack_d  = !owner_q;
                    d_ack_d  = owner_q;
                    state_d  = S_RESP;
                end else if (timer_q == TMO_LAST) begin
                    c_macc_d = 1'b0;
                    i_ack_d  = !owner_q;
                    d_ack_d  = owner_q;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                // One-cycle macc-low gap; requests ignored here.
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                c_macc_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            c_macc_q <= 1'b0;
            c_rd_q   <= 1'b1;
            c_addr_q <= '0;
            c_din_q  <= '0;
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            i_dout_q <= '0;
            d_dout_q <= '0;
            busy_q   <= 1'b0;
            timer_q  <= '0;
            owner_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            c_macc_q <= c_macc_d;
            c_rd_q   <= c_rd_d;
            c_addr_q <= c_addr_d;
            c_din_q  <= c_din_d;
            i_ack_q  <= i_ack_d;
            d_ack_q  <= d_ack_d;
            err_q    <= err_d;
            i_dout_q <= i_dout_d;
            d_dout_q <= d_dout_d;
            busy_q   <= busy_d;
            timer_q  <= timer_d;
            owner_q  <= owner_d;
        end
    end

    assign c_macc = c_macc_q;
    assign c_rd   = c_rd_q;
    assign c_addr = c_addr_q;
    assign c_din  = c_din_q;
    assign i_ack  = i_ack_q;
    assign d_ack  = d_ack_q;
    assign err    = err_q;
    assign i_dout = i_dout_q;
    assign d_dout = d_dout_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_unified_cache_arbiter.sv
// Self-checking bench for unified_cache_arbiter: directed scenarios followed by
// randomized request traffic, checked against a transaction-level model.
module tb_unified_cache_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_dout;
    logic          d_req = 1'b0;
    logic          d_rd = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_din = '0;
    logic          d_ack;
    logic [DW-1:0] d_dout;
    logic          err;
    logic          busy;
    logic          c_macc;
    logic          c_rd;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_din;
    logic [DW-1:0] c_dout = '0;
    logic          c_complete = 1'b0;

    unified_cache_arbiter #(.AW(AW), .DW(DW), .TMO_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_dout(i_dout),
        .d_req(d_req), .d_rd(d_rd), .d_addr(d_addr), .d_din(d_din),
        .d_ack(d_ack), .d_dout(d_dout), .err(err), .busy(busy),
        .c_macc(c_macc), .c_rd(c_rd), .c_addr(c_addr), .c_din(c_din),
        .c_dout(c_dout), .c_complete(c_complete)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] m_idout = '0;
    logic [DW-1:0] m_ddout = '0;
    logic [DW-1:0] m_cdin  = '0;
    bit            m_last_d = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: lone requester wins; tie -> data port, or the port
    // that did not win last time when round robin is enabled.
    function automatic bit model_pick_d();
        if (i_req && d_req) return RR ? !m_last_d : 1'b1;
        return d_req;
    endfunction

    // Run one access from grant to the following idle cycle. lat = number of
    // macc-high cycles before the cache completes (0 = cache never completes).
    task automatic serve(input int lat, input logic [DW-1:0] data, output int ack_cyc);
        bit            w_d;
        bit            done;
        bit            completed;
        int            k;
        logic [AW-1:0] ea;
        logic          erd;
        w_d = model_pick_d();
        ea  = w_d ? d_addr : i_addr;
        erd = w_d ? d_rd : 1'b1;
        if (w_d) m_cdin = d_din;
        m_last_d = w_d;
        @(posedge clock); @(negedge clock);
        chk("grant_macc", 32'(c_macc), 32'd1);
        chk("grant_addr", 32'(c_addr), 32'(ea));
        chk("grant_rd",   32'(c_rd),   32'(erd));
        chk("grant_din",  32'(c_din),  32'(m_cdin));
        chk("grant_busy", 32'(busy),   32'd1);
        k = 1;
        done = 1'b0;
        while (!done) begin
            if (k == lat) begin
                c_complete = 1'b1;
                c_dout     = data;
            end else begin
                c_complete = 1'b0;
                c_dout     = DW'($urandom);
            end
            @(posedge clock); @(negedge clock);
            if (k == lat || k == int'(TMO)) begin
                done = 1'b1;
            end else begin
                chk("macc_hold", 32'({c_macc, c_addr}), 32'({1'b1, ea}));
                k++;
            end
        end
        c_complete = 1'b0;
        completed = (k == lat);
        if (completed && erd) begin
            if (w_d) m_ddout = data;
            else     m_idout = data;
        end
        ack_cyc = cyc;
        chk("resp_i_ack",  32'(i_ack),  32'(!w_d));
        chk("resp_d_ack",  32'(d_ack),  32'(w_d));
        chk("resp_err",    32'(err),    32'(!completed));
        chk("resp_i_dout", 32'(i_dout), 32'(m_idout));
        chk("resp_d_dout", 32'(d_dout), 32'(m_ddout));
        chk("resp_macc",   32'(c_macc), 32'd0);
        if (w_d) d_req = 1'b0;
        else     i_req = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("idle_macc", 32'(c_macc), 32'd0);
        chk("idle_busy", 32'(busy),   32'd0);
        chk("idle_acks", 32'({i_ack, d_ack, err}), 32'd0);
    endtask

    initial begin
        int t0, t1, t2, r, lat;
        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst_macc",  32'(c_macc), 32'd0);
        chk("rst_rd",    32'(c_rd),   32'd1);
        chk("rst_addr",  32'(c_addr), 32'd0);
        chk("rst_din",   32'(c_din),  32'd0);
        chk("rst_acks",  32'({i_ack, d_ack, err}), 32'd0);
        chk("rst_douts", 32'({i_dout, d_dout}), 32'd0);
        chk("rst_busy",  32'(busy),   32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single fetch.
        i_req = 1'b1; i_addr = 16'h0040;
        serve(3, 16'hBEEF, t0);

        // Data write: d_dout must stay unchanged.
        d_req = 1'b1; d_rd = 1'b0; d_addr = 16'h1234; d_din = 16'h5A5A;
        serve(1, 16'hFFFF, t0);

        // Timeout, then completion on the last allowed cycle.
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h0777;
        serve(0, 16'h0000, t0);
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h0778;
        serve(int'(TMO), 16'h1357, t0);

        // Both ports requesting for four accesses.
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h0200;
        for (int n = 0; n < 4; n++) begin
            serve(2, 16'h7000 + 16'(n), t0);
            if (!i_req) begin i_req = 1'b1; i_addr = 16'h0100 + 16'(n); end
            if (!d_req) begin d_req = 1'b1; d_addr = 16'h0200 + 16'(n); end
        end
        // Drain whichever request is still pending.
        serve(1, 16'h7777, t0);
        if (i_req || d_req) serve(1, 16'h7778, t0);

        // Back-to-back data requests completing immediately: ack spacing 3.
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h0300;
        serve(1, 16'hA001, t0);
        d_req = 1'b1; d_addr = 16'h0301;
        serve(1, 16'hA002, t1);
        d_req = 1'b1; d_addr = 16'h0302;
        serve(1, 16'hA003, t2);
        chk("ack_spacing1", 32'(t1 - t0), 32'd3);
        chk("ack_spacing2", 32'(t2 - t1), 32'd3);

        // Reset two cycles into an access.
        i_req = 1'b1; i_addr = 16'h0400;
        @(posedge clock); @(negedge clock);
        chk("mid_macc_up", 32'(c_macc), 32'd1);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_macc", 32'(c_macc), 32'd0);
        chk("mid_rst_busy", 32'(busy),   32'd0);
        chk("mid_rst_acks", 32'({i_ack, d_ack, err}), 32'd0);
        i_req = 1'b0;
        m_idout = '0; m_ddout = '0; m_cdin = '0; m_last_d = 1'b1;
        @(negedge clock);
        chk("mid_rst_ack_hold", 32'({i_ack, c_macc}), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        i_req = 1'b1; i_addr = 16'h0500;
        serve(2, 16'hC0DE, t0);

        // Randomized traffic; losing requests stay pending with stable fields.
        for (int n = 0; n < 40; n++) begin
            if (!i_req && ($urandom % 2 == 0)) begin
                i_req = 1'b1; i_addr = AW'($urandom);
            end
            if (!d_req && ($urandom % 2 == 0)) begin
                d_req = 1'b1; d_rd = 1'($urandom);
                d_addr = AW'($urandom); d_din = DW'($urandom);
            end
            if (!i_req && !d_req) begin
                i_req = 1'b1; i_addr = AW'($urandom);
            end
            r = int'($urandom % 10);
            if (r == 0)      lat = 0;
            else if (r == 1) lat = int'(TMO);
            else             lat = 1 + int'($urandom % 4);
            serve(lat, DW'($urandom), t0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_cache_arbiter.md
Name: unified_cache_arbiter

Overview:
Two-requester front end for the unified cache processor interface. Arbitrates between an instruction-fetch port (read-only) and a data port (read/write), and registers the winner's address, data and direction. It drives the cache's macc/rd/addr/din handshake until complete arrives, then returns data and an ack to the winner. A watchdog aborts a cache access that never completes.

Parameters:
AW, 16, address width (matches cache addr)
DW, 16, data width (matches cache din/dout)
TMO_CYCLES, 64, max cycles macc may stay high before abort; legal range 2..255

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  instruction fetch request, level; held until i_ack
i_addr  in  AW  fetch address; stable while i_req=1
i_ack  out  1  one-cycle pulse: fetch finished
i_dout  out  DW  fetch data; valid with i_ack, held until next i_ack
d_req  in  1  data request, level; held until d_ack
d_rd  in  1  1=read, 0=write
d_addr  in  AW  data address
d_din  in  DW  write data
d_ack  out  1  one-cycle pulse: data access finished
d_dout  out  DW  read data; valid with d_ack (write: holds previous value)
err  out  1  one-cycle pulse with ack when the access timed out
busy  out  1  1 whenever state != IDLE
c_macc  out  1  cache access strobe
c_rd  out  1  cache direction
c_addr  out  AW  cache address
c_din  out  DW  cache write data
c_dout  in  DW  cache read data
c_complete  in  1  cache done; sampled only while c_macc=1

Behaviour:
- All outputs registered. On reset low (async): state=IDLE; c_macc=0, c_rd=1, c_addr=0, c_din=0; i_ack=d_ack=err=0; i_dout=d_dout=0; busy=0; timer=0; last_grant=D.
- States: IDLE, ISSUE, RESP.
- IDLE: if any req is high at a clock edge, pick a winner. Latch its addr/din/rd into c_addr/c_din/c_rd (instruction port: c_rd=1, c_din unchanged), set c_macc=1, go to ISSUE. Timer loads 0.
- Tie (both req=1): data port wins (fixed priority); see optional feature.
- ISSUE: c_macc, c_addr, c_din and c_rd stay stable. Timer increments each cycle.
  - On an edge with c_complete=1: capture c_dout into winner's dout register if c_rd=1. Drop c_macc, pulse the winner's ack, go to RESP.
  - If the timer reaches TMO_CYCLES-1 with c_complete=0: drop c_macc, pulse the winner's ack and err, leave the dout register unchanged, go to RESP.
  - If complete and timeout occur on the same edge, complete wins and err=0.
- RESP: lasts exactly one cycle with ack/err high and c_macc=0, guaranteeing a one-cycle macc-low gap. Requests are ignored. Then go to IDLE.
- Requester rule: drop req on the edge that samples ack. A req still high in the following IDLE cycle is a new request.
- Latency: req seen at edge N -> c_macc=1 after edge N. c_complete seen at edge M -> ack after edge M. Earliest next c_macc is after edge M+2.
- Back-to-back requests from the same port are permitted. A losing request is held pending with no timeout.
- req dropped before ack: illegal; the access still runs to completion and the ack is still pulsed.
- reset mid-ISSUE: c_macc drops immediately (async). No ack is produced and the pending access is lost.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: a tie goes to the port not recorded in last_grant. last_grant updates at every grant; reset value D, so the first tie goes to I. Continuous requests from both ports alternate I, D, I, D.
- Undefined: fixed data-port priority; last_grant logic is not built.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0040; cache returns complete after 3 cycles with c_dout=0xBEEF -> c_macc high 3 cycles, c_rd=1, c_addr=0x0040; i_ack pulse with i_dout=0xBEEF; err=0.
- Data write: d_req=1, d_rd=0, d_addr=0x1234, d_din=0x5A5A; complete after 1 cycle -> c_rd=0, c_din=0x5A5A; d_ack pulse; d_dout unchanged.
- Simultaneous requests, macro off: i_req=d_req=1 held for 4 accesses -> grant order D,D,D,D while I waits; with ARB_ROUND_ROBIN_EN -> I,D,I,D.
- Timeout at TMO_CYCLES=8: c_complete never asserted -> c_macc high exactly 8 cycles, then ack+err pulse together, dout unchanged. A complete on the 8th cycle instead -> err=0.
- Gap check: complete on every cycle c_macc is high, with back-to-back d_req -> c_macc always low for ≥1 cycle between accesses; ack spacing 3 cycles.
- Reset mid-access: assert reset low 2 cycles into ISSUE -> c_macc=0 immediately, no ack, busy=0. After release a new i_req is serviced normally.
